pipe_stall_flush_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipelined CPU. Merges the load-use hazard

---
 rtl/pipe_stall_flush_ctrl_pkg.sv | 27 ++
 rtl/pipe_stall_flush_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_stall_flush_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_stall_flush_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_flush_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states and the
// bit layout of the packed control vector that drives the pipeline registers.
package pipe_stall_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun = 2'd0,
        StLu  = 2'd1,
        StMdu = 2'd2
    } state_e;

    localparam int unsigned CtlW        = 7;
    localparam int unsigned CtlPcWr     = 6;
    localparam int unsigned CtlIfIdWr   = 5;
    localparam int unsigned CtlIdExWr   = 4;
    localparam int unsigned CtlIfIdFl   = 3;
    localparam int unsigned CtlIdExFl   = 2;
    localparam int unsigned CtlExMemFl  = 1;
    localparam int unsigned CtlAbort    = 0;

    // {pc_wr, if_id_wr, id_ex_wr, if_id_fl, id_ex_fl, ex_mem_fl, abort}
    localparam logic [CtlW-1:0] CtlRun      = 7'b111_000_0;
    localparam logic [CtlW-1:0] CtlReset    = 7'b000_111_0;
    localparam logic [CtlW-1:0] CtlBranch   = 7'b111_111_0;
    localparam logic [CtlW-1:0] CtlMduStall = 7'b000_001_0;
    localparam logic [CtlW-1:0] CtlLuStall  = 7'b001_010_0;

endpackage

// File: rtl/pipe_stall_flush_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module pipe_stall_flush_ctrl_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_flush_ctrl.sv
// Central stall/flush sequencer: merges taken-branch, MDU handshake and load-use
// requests (in that priority) into pipeline-register write enables and flushes.
module pipe_stall_flush_ctrl
    import pipe_stall_flush_ctrl_pkg::*;
#(
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned MDU_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             mdu_start_i,
    input  logic             mdu_done_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mdu_abort_o,
    output logic             mdu_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned ToW = $clog2(MDU_TIMEOUT);
    localparam logic [ToW-1:0] ToLast = ToW'(MDU_TIMEOUT - 1);
    // lu_cnt counts bubbles already issued; the last one is issued when lu_cnt+1 reaches the limit
    localparam logic [1:0] LuLast = 2'(LU_STALL_CYC - 1);

    state_e         state_q, state_d;
    logic [1:0]     lu_cnt_q, lu_cnt_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           err_q, err_d;
    logic [CtlW-1:0] ctl;
    logic           to_hit;

    assign to_hit = (state_q == StMdu) && (to_cnt_q == ToLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StRun;
            lu_cnt_q <= '0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (branch_taken_i) begin
            state_d  = StRun;
            lu_cnt_d = '0;
            to_cnt_d = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (mdu_start_i) begin
                        if (!mdu_done_i) begin
                            state_d  = StMdu;
                            to_cnt_d = ToW'(1);
                        end
                    end else if (load_use_i) begin
                        lu_cnt_d = 2'd1;
                        if (LU_STALL_CYC > 1) state_d = StLu;
                    end
                end
                StLu: begin
                    lu_cnt_d = lu_cnt_q + 2'd1;
                    if (lu_cnt_q == LuLast) state_d = StRun;
                end
                StMdu: begin
                    if (mdu_done_i) begin
                        state_d = StRun;
                    end else begin
                        to_cnt_d = to_cnt_q + ToW'(1);
                        if (to_hit) begin
                            state_d = StRun;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        ctl = CtlRun;
        if (rst_i) begin
            ctl = CtlReset;
        end else if (branch_taken_i) begin
            ctl           = CtlBranch;
            ctl[CtlAbort] = (state_q == StMdu) || mdu_start_i;
        end else begin
            case (state_q)
                StRun: begin
                    if (mdu_start_i) begin
                        ctl = mdu_done_i ? CtlRun : CtlMduStall;
                    end else if (load_use_i) begin
                        ctl = CtlLuStall;
                    end
                end
                StLu: ctl = CtlLuStall;
                StMdu: begin
                    if (!mdu_done_i) begin
                        ctl           = CtlMduStall;
                        ctl[CtlAbort] = to_hit;
                    end
                end
                default: ctl = CtlRun;
            endcase
        end
    end

    assign pc_write_o     = ctl[CtlPcWr];
    assign if_id_write_o  = ctl[CtlIfIdWr];
    assign id_ex_write_o  = ctl[CtlIdExWr];
    assign if_id_flush_o  = ctl[CtlIfIdFl];
    assign id_ex_flush_o  = ctl[CtlIdExFl];
    assign ex_mem_flush_o = ctl[CtlExMemFl];
    assign mdu_abort_o    = ctl[CtlAbort];
    assign mdu_err_o      = err_q;

    pipe_stall_flush_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!rst_i && !ctl[CtlPcWr]),
        .cnt_o (stall_cnt_o)
    );

    pipe_stall_flush_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!rst_i && branch_taken_i),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Scoreboard bench for pipe_stall_flush_ctrl: directed scenarios then random traffic,
// checked against a bubble-counting reference model.
module tb_pipe_stall_flush_ctrl;

    localparam int LU  = 2;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [6:0]    ctl;
        logic          err;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1, load_use = 1'b0, branch = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0;
    logic pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic mdu_abort, mdu_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // reference model: remaining load-use bubbles, outstanding MDU op and its age
    int m_lu_left = 0, m_age = 0, m_stalls = 0, m_flushes = 0;
    bit m_busy = 0, m_err = 0;

    always #5 clk = ~clk;

    pipe_stall_flush_ctrl #(
        .LU_STALL_CYC (LU),
        .MDU_TIMEOUT  (TO),
        .CNT_W        (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .load_use_i     (load_use),
        .branch_taken_i (branch),
        .mdu_start_i    (mdu_start),
        .mdu_done_i     (mdu_done),
        .pc_write_o     (pc_write),
        .if_id_write_o  (if_id_write),
        .id_ex_write_o  (id_ex_write),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .ex_mem_flush_o (ex_mem_flush),
        .mdu_abort_o    (mdu_abort),
        .mdu_err_o      (mdu_err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    task automatic drive(input bit r, input bit lu, input bit br, input bit ms, input bit md);
        exp_t     e;
        bit [6:0] c;
        @(posedge clk);
        #1;
        rst = r; load_use = lu; branch = br; mdu_start = ms; mdu_done = md;
        e.err   = m_err;
        e.stall = CW'(m_stalls);
        e.flush = CW'(m_flushes);
        c = 7'b1110000;
        if (r) begin
            c = 7'b0001110;
            m_lu_left = 0; m_busy = 0; m_age = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (br) begin
                c = 7'b1111110;
                c[0] = m_busy || ms;
                m_busy = 0;
                m_lu_left = 0;
                if (m_flushes < MAXC) m_flushes++;
            end else if (m_busy) begin
                if (md) begin
                    m_busy = 0;
                end else begin
                    c = 7'b0000010;
                    m_age++;
                    if (m_age == TO) begin
                        c[0] = 1'b1;
                        m_err = 1;
                        m_busy = 0;
                    end
                end
            end else if (m_lu_left > 0) begin
                c = 7'b0010100;
                m_lu_left--;
            end else if (ms) begin
                if (!md) begin
                    c = 7'b0000010;
                    m_busy = 1;
                    m_age = 1;
                end
            end else if (lu) begin
                c = 7'b0010100;
                m_lu_left = LU - 1;
            end
            if (!c[6] && m_stalls < MAXC) m_stalls++;
        end
        e.ctl = c;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t     e;
        bit [6:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                       ex_mem_flush, mdu_abort};
                n_checks++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl t=%0t got %b want %b", $time, act, e.ctl);
                end
                n_checks++;
                if (mdu_err !== e.err) begin
                    n_fail++;
                    $display("FAIL mdu_err t=%0t got %b want %b", $time, mdu_err, e.err);
                end
                n_checks++;
                if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
                    n_fail++;
                    $display("FAIL counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             $time, stall_cnt, flush_cnt, e.stall, e.flush);
                end
            end
        end
    end

    initial begin : stimulus
        bit lu, br, ms, md;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
        idle(2);
        // single load-use pulse
        drive(0, 1, 0, 0, 0);
        idle(4);
        // MDU op completing after four stalled cycles
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        idle(2);
        // MDU start and done together, done in RUN without an op
        drive(0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        idle(3);
        // branch with MDU start, then branch during load-use stall
        drive(0, 0, 1, 1, 0);
        idle(1);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(2);
        // branch while waiting on MDU
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        idle(2);
        // MDU timeout, sticky error, reset mid-stall
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle(2);
        // counter saturation
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) drive(0, 0, 1, 0, 0);
        idle(2);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            br = ($urandom_range(0, 11) == 0);
            lu = ($urandom_range(0, 3) == 0);
            ms = (m_lu_left == 0) && ($urandom_range(0, 7) == 0);
            md = ($urandom_range(0, 5) == 0);
            drive(($urandom_range(0, 199) == 0), lu, br, ms, md);
        end
        idle(2);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
